// File: rtl/dump_pulse_gen.sv
// Multi-channel dump-off pulse generator: per-channel delay / width / repeat
// sequences with optional one-shot auto-fire. Define DUMPOFF_ABORT_EN for a global abort.
module dump_pulse_gen #(
  parameter int             NCH       = 4,
  parameter int             CNT_W     = 8,
  parameter logic [NCH-1:0] AUTO_MASK = '0,
  parameter int             AUTO_DLY  = 1,
  parameter int             AUTO_WID  = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       trig,
  input  logic [NCH*CNT_W-1:0] dly,
  input  logic [NCH*CNT_W-1:0] wid,
  input  logic [NCH*4-1:0]     rep,
`ifdef DUMPOFF_ABORT_EN
  input  logic                 abort,
`endif
  output logic [NCH-1:0]       dumpoff,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DLY  = 2'd1,
    ON   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] AUTO_D = CNT_W'(AUTO_DLY);
  localparam logic [CNT_W-1:0] AUTO_W = CNT_W'(AUTO_WID);

  logic kill;
`ifdef DUMPOFF_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  // Set while in reset; the first non-reset edge consumes it, so auto-fire is one-shot.
  logic auto_arm;
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for every register, so all flops see pre-edge values.
    if (reset) auto_arm <= 1'b1;
    else       auto_arm <= 1'b0;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] d_q;
    logic [CNT_W-1:0] w_q;
    logic [3:0]       left;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;

    logic             auto_go;
    logic [CNT_W-1:0] start_d;
    logic [CNT_W-1:0] start_w;
    logic [3:0]       start_r;
    logic             start;

    assign auto_go = auto_arm && AUTO_MASK[i];
    assign start_d = auto_go ? AUTO_D : dly[i*CNT_W +: CNT_W];
    assign start_w = auto_go ? AUTO_W : wid[i*CNT_W +: CNT_W];
    assign start_r = auto_go ? 4'd1   : rep[i*4 +: 4];
    assign start   = (auto_go || trig[i]) && (st == IDLE) && (start_w != '0);

    always_ff @(posedge clk) begin
      if (reset || kill) begin
        st      <= IDLE;
        cnt     <= '0;
        d_q     <= '0;
        w_q     <= '0;
        left    <= '0;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        case (st)
          IDLE: begin
            if (start) begin
              d_q    <= start_d;
              w_q    <= start_w;
              left   <= (start_r == 4'd0) ? 4'd1 : start_r;
              cnt    <= start_d;
              busy_q <= 1'b1;
              st     <= DLY;
            end
          end
          DLY: begin
            if (cnt == '0) begin
              pulse_q <= 1'b1;
              cnt     <= w_q - 1'b1;
              st      <= ON;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ON: begin
            if (cnt == '0) begin
              pulse_q <= 1'b0;
              if (left > 4'd1) begin
                // Inter-pulse gap is max(D,1) edges; DLY rises after cnt+1 edges.
                left <= left - 4'd1;
                cnt  <= (d_q == '0) ? '0 : d_q - 1'b1;
                st   <= DLY;
              end else begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                st     <= IDLE;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end

    assign dumpoff[i] = pulse_q;
    assign busy[i]    = busy_q;
    assign done[i]    = done_q;
  end

endmodule

// File: tb/tb_dump_pulse_gen.sv
// Scoreboard bench for dump_pulse_gen: stimulus pushes expected rise/fall/done
// edges per channel; a negedge monitor pops and compares each observed event.
module tb_dump_pulse_gen;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;
  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_DONE = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       trig;
  logic [NCH*CNT_W-1:0] dly;
  logic [NCH*CNT_W-1:0] wid;
  logic [NCH*4-1:0]     rep;
  logic                 abort;
  logic [NCH-1:0]       dumpoff;
  logic [NCH-1:0]       busy;
  logic [NCH-1:0]       done;

  dump_pulse_gen #(
    .NCH      (NCH),
    .CNT_W    (CNT_W),
    .AUTO_MASK(4'b0001),
    .AUTO_DLY (1),
    .AUTO_WID (19)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .trig   (trig),
    .dly    (dly),
    .wid    (wid),
    .rep    (rep),
`ifdef DUMPOFF_ABORT_EN
    .abort  (abort),
`endif
    .dumpoff(dumpoff),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t exp_q[NCH][$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;
  logic [NCH-1:0] prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int ch, input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q[ch].push_back(e);
  endtask

  task automatic observe(input int ch, input int kind);
    ev_t   e;
    string nm;
    nm = $sformatf("ch%0d_%s", ch, kind == K_RISE ? "rise" : kind == K_FALL ? "fall" : "done");
    if (exp_q[ch].size() == 0) begin
      check(1'b0, {nm, "_unexpected"}, cyc, -1);
    end else begin
      e = exp_q[ch].pop_front();
      check(e.kind == kind && e.at == cyc, nm, cyc, (e.kind == kind) ? e.at : -e.kind - 1);
    end
  endtask

  // Edge numbers: cyc holds the index of the most recent rising edge at each negedge.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (dumpoff[c] && !prev[c]) observe(c, K_RISE);
      if (!dumpoff[c] && prev[c]) observe(c, K_FALL);
      if (done[c])                observe(c, K_DONE);
    end
    prev = dumpoff;
  end

  task automatic cfg(input int c, input int d, input int w, input int r);
    dly[c*CNT_W +: CNT_W] = CNT_W'(d);
    wid[c*CNT_W +: CNT_W] = CNT_W'(w);
    rep[c*4 +: 4]         = 4'(r);
  endtask

  function automatic int pending();
    int n = 0;
    for (int c = 0; c < NCH; c++) n += exp_q[c].size();
    return n;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(n < budget, "wait_idle_timeout", n, budget);
  endtask

  task automatic expect_auto(input int e0);
    expect_ev(0, K_RISE, e0 + 2);
    expect_ev(0, K_FALL, e0 + 21);
    expect_ev(0, K_DONE, e0 + 21);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    trig  = '0;
    dly   = '0;
    wid   = '0;
    rep   = '0;
    abort = 1'b0;

    // Reset held: all outputs stay low.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check(dumpoff == '0, "rst_dumpoff", int'(dumpoff), 0);
      check(busy == '0,    "rst_busy",    int'(busy),    0);
      check(done == '0,    "rst_done",    int'(done),    0);
    end

    // Release: ch0 auto-fires (D=1, W=19) at the first non-reset edge.
    reset = 1'b0;
    expect_auto(cyc + 1);
    @(negedge clk);
    check(busy == 4'b0001, "auto_busy", int'(busy), 1);

    // ch1 D=3 W=5 R=2 and ch2 D=0 W=1 R=0 triggered together.
    cfg(1, 3, 5, 2);
    cfg(2, 0, 1, 0);
    trig = 4'b0110;
    t = cyc + 1;
    expect_ev(1, K_RISE, t + 4);
    expect_ev(1, K_FALL, t + 9);
    expect_ev(1, K_RISE, t + 12);
    expect_ev(1, K_FALL, t + 17);
    expect_ev(1, K_DONE, t + 17);
    expect_ev(2, K_RISE, t + 1);
    expect_ev(2, K_FALL, t + 2);
    expect_ev(2, K_DONE, t + 2);
    @(negedge clk);
    trig = '0;
    check(busy[2:1] == 2'b11, "multi_start_busy", int'(busy[2:1]), 3);
    wait_idle(100);

    // wid=0 is ignored entirely.
    cfg(2, 0, 0, 1);
    trig[2] = 1'b1;
    @(negedge clk);
    trig[2] = 1'b0;
    check(busy[2] == 1'b0, "wid0_busy", int'(busy[2]), 0);

    // ch3: trig held through the sequence with dly changed; retrigger at done+1.
    cfg(3, 2, 3, 1);
    trig[3] = 1'b1;
    t = cyc + 1;
    expect_ev(3, K_RISE, t + 3);
    expect_ev(3, K_FALL, t + 6);
    expect_ev(3, K_DONE, t + 6);
    expect_ev(3, K_RISE, t + 9);
    expect_ev(3, K_FALL, t + 11);
    expect_ev(3, K_DONE, t + 11);
    @(negedge clk);
    cfg(3, 7, 9, 3);
    while (cyc < t + 6) @(negedge clk);
    cfg(3, 1, 2, 1);
    @(negedge clk);
    trig[3] = 1'b0;
    check(busy[3] == 1'b1, "b2b_busy", int'(busy[3]), 1);
    wait_idle(100);

    // Counter extremes: D=255 on ch2, W=255 on ch3.
    cfg(2, 255, 2, 1);
    cfg(3, 0, 255, 1);
    trig = 4'b1100;
    t = cyc + 1;
    expect_ev(2, K_RISE, t + 256);
    expect_ev(2, K_FALL, t + 258);
    expect_ev(2, K_DONE, t + 258);
    expect_ev(3, K_RISE, t + 1);
    expect_ev(3, K_FALL, t + 256);
    expect_ev(3, K_DONE, t + 256);
    @(negedge clk);
    trig = '0;
    wait_idle(400);

    // Reset mid-pulse on ch1 cuts it off with no done; auto-fire re-arms.
    cfg(1, 0, 10, 1);
    trig[1] = 1'b1;
    t = cyc + 1;
    expect_ev(1, K_RISE, t + 1);
    @(negedge clk);
    trig[1] = 1'b0;
    while (cyc < t + 3) @(negedge clk);
    reset = 1'b1;
    trig[1] = 1'b1;
    expect_ev(1, K_FALL, t + 4);
    @(negedge clk);
    check(busy == '0,    "midrst_busy",    int'(busy),    0);
    check(dumpoff == '0, "midrst_dumpoff", int'(dumpoff), 0);
    trig[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    expect_auto(cyc + 1);
    wait_idle(100);

`ifdef DUMPOFF_ABORT_EN
    // Abort during ch0 delay, with trig[1] on the same edge.
    cfg(0, 5, 3, 1);
    cfg(1, 0, 4, 1);
    trig[0] = 1'b1;
    @(negedge clk);
    trig[0] = 1'b0;
    check(busy[0] == 1'b1, "pre_abort_busy", int'(busy[0]), 1);
    abort   = 1'b1;
    trig[1] = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    trig  = '0;
    check(busy == '0,    "abort_busy",    int'(busy),    0);
    check(dumpoff == '0, "abort_dumpoff", int'(dumpoff), 0);
`endif

    // Quiet window: any stray event shows up as unexpected.
    repeat (30) @(negedge clk);
    for (int c = 0; c < NCH; c++)
      check(exp_q[c].size() == 0, $sformatf("ch%0d_leftover", c), exp_q[c].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
